// File: rtl/riscv_pkg.sv
// Shared RV32M definitions: M-extension funct3 codes, multiply/divide FSM states
// and the per-op operand signedness helpers.
package riscv_pkg;

   typedef enum logic [2:0] {
      F3_MUL    = 3'b000,
      F3_MULH   = 3'b001,
      F3_MULHSU = 3'b010,
      F3_MULHU  = 3'b011,
      F3_DIV    = 3'b100,
      F3_DIVU   = 3'b101,
      F3_REM    = 3'b110,
      F3_REMU   = 3'b111
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } md_state_e;

   function automatic logic op_a_signed(input logic [2:0] f3);
      logic s;
      case (f3)
         F3_MULH, F3_MULHSU, F3_DIV, F3_REM: s = 1'b1;
         default:                            s = 1'b0;
      endcase
      return s;
   endfunction

   function automatic logic op_b_signed(input logic [2:0] f3);
      logic s;
      case (f3)
         F3_MULH, F3_DIV, F3_REM: s = 1'b1;
         default:                 s = 1'b0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/md_operand_prep.sv
// Converts the latched operands into unsigned magnitudes and derives the sign
// corrections that the FIX step applies to the product, quotient or remainder.
module md_operand_prep
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic [XLEN-1:0] mag_a,
   output logic [XLEN-1:0] mag_b,
   output logic            is_div,
   output logic            neg_res,
   output logic            neg_rem,
   output logic            div_zero
);

   logic neg_a;
   logic neg_b;

   assign neg_a    = op_a_signed(funct3) & op_a[XLEN-1];
   assign neg_b    = op_b_signed(funct3) & op_b[XLEN-1];
   assign mag_a    = neg_a ? -op_a : op_a;
   assign mag_b    = neg_b ? -op_b : op_b;
   assign is_div   = funct3[2];
   // Product and quotient are negative exactly when the operand signs differ.
   assign neg_res  = neg_a ^ neg_b;
   assign neg_rem  = neg_a;
   assign div_zero = (op_b == '0);

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-divide steps,
// one sign-fix step and a one-cycle done pulse, for a fixed latency on every op.
module mul_div_unit
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic [4:0]      rd_in,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out,
   output logic            we_out
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

   md_state_e       state_reg, state_next;
   logic [CW-1:0]   cnt_reg;
   md_op_e          funct3_reg;
   logic [XLEN-1:0] op_a_reg, op_b_reg;
   logic [4:0]      rd_reg, rd_out_reg;
   logic [XLEN-1:0] hi_reg, lo_reg, result_reg;

   logic [XLEN-1:0] mag_a, mag_b;
   logic            is_div, neg_res, neg_rem, div_zero;
   logic            accept;

   md_operand_prep #(.XLEN(XLEN)) u_prep (
      .funct3   (funct3_reg),
      .op_a     (op_a_reg),
      .op_b     (op_b_reg),
      .mag_a    (mag_a),
      .mag_b    (mag_b),
      .is_div   (is_div),
      .neg_res  (neg_res),
      .neg_rem  (neg_rem),
      .div_zero (div_zero)
   );

   assign accept = (state_reg == ST_IDLE) && start;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= ST_IDLE;
      else      state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (start) state_next = ST_CALC;
         ST_CALC: if (cnt_reg == CNT_LAST) state_next = ST_FIX;
         ST_FIX:  state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy   = (state_reg != ST_IDLE);
      done   = (state_reg == ST_DONE);
      we_out = (state_reg == ST_DONE) && (rd_out_reg != 5'd0);
      result = result_reg;
      rd_out = rd_out_reg;
   end

   // Magnitudes only exist once the operands are latched, so the first CALC step
   // takes its shift operand straight from the prep outputs.
   logic [XLEN-1:0] lo_eff;
   logic [XLEN:0]   mul_sum;
   logic [XLEN:0]   rem_shift;
   logic [XLEN:0]   div_diff;
   logic            q_bit;
   logic [XLEN-1:0] hi_step, lo_step;

   always_comb begin
      lo_eff    = (cnt_reg == '0) ? (is_div ? mag_a : mag_b) : lo_reg;
      mul_sum   = {1'b0, hi_reg} + (lo_eff[0] ? {1'b0, mag_a} : '0);
      rem_shift = {hi_reg, lo_eff[XLEN-1]};
      div_diff  = rem_shift - {1'b0, mag_b};
      q_bit     = ~div_diff[XLEN];
      if (is_div) begin
         hi_step = q_bit ? div_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
         lo_step = {lo_eff[XLEN-2:0], q_bit};
      end else begin
         hi_step = mul_sum[XLEN:1];
         lo_step = {mul_sum[0], lo_eff[XLEN-1:1]};
      end
   end

   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quot_fix, rem_fix, result_fix;

   always_comb begin
      prod_fix = neg_res ? -{hi_reg, lo_reg} : {hi_reg, lo_reg};
      // Division by zero keeps the all-ones quotient whatever the dividend sign.
      quot_fix = div_zero ? '1 : (neg_res ? -lo_reg : lo_reg);
      rem_fix  = neg_rem ? -hi_reg : hi_reg;
      case (funct3_reg)
         F3_MUL:                      result_fix = prod_fix[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: result_fix = prod_fix[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:             result_fix = quot_fix;
         default:                     result_fix = rem_fix;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg    <= '0;
         funct3_reg <= F3_MUL;
         op_a_reg   <= '0;
         op_b_reg   <= '0;
         rd_reg     <= '0;
         hi_reg     <= '0;
         lo_reg     <= '0;
         result_reg <= '0;
         rd_out_reg <= '0;
      end else if (accept) begin
         cnt_reg    <= '0;
         funct3_reg <= md_op_e'(funct3);
         op_a_reg   <= op_a;
         op_b_reg   <= op_b;
         rd_reg     <= rd_in;
         hi_reg     <= '0;
         lo_reg     <= '0;
      end else if (state_reg == ST_CALC) begin
         cnt_reg <= cnt_reg + CW'(1);
         hi_reg  <= hi_step;
         lo_reg  <= lo_step;
      end else if (state_reg == ST_FIX) begin
         result_reg <= result_fix;
         rd_out_reg <= rd_reg;
      end
   end

endmodule
